hub75_scan_sched: RTL



---
 rtl/hub75_pkg.sv | 26 ++
 rtl/hub75_plane_timer.sv | 30 +++
 rtl/hub75_scan_sched.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 scan path: one-hot display states and
// the elaboration-time helpers that size the plane timer.
package hub75_pkg;

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_WAIT    = 6'b000010,
        S_BLANK   = 6'b000100,
        S_LATCH   = 6'b001000,
        S_UNBLANK = 6'b010000,
        S_DISPLAY = 6'b100000
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // Wide enough to hold the longest plane weight without truncation.
    function automatic int timer_width(input int base_cycles, input int planes);
        return clog2(base_cycles << (planes - 1)) + 1;
    endfunction

endpackage

// File: rtl/hub75_plane_timer.sv
// Loadable down-counter for the display time of one bit plane; saturates
// at zero and flags it.
module hub75_plane_timer
    import hub75_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hub75_scan_sched.sv
// Row/bit-plane scheduler: issues one shift per slot and runs the
// blank/latch/display sequence, overlapping the next shift with display.
module hub75_scan_sched
    import hub75_pkg::*;
#(
    parameter int COLS        = 32,
    parameter int ROWS        = 32,
    parameter int ROWBITS     = 5,
    parameter int PLANES      = 8,
    parameter int PLANEBITS   = 3,
    parameter int BASE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic                 shift_valid,
    input  logic                 shift_ready,
    output logic [ROWBITS-1:0]   shift_row,
    output logic [PLANEBITS-1:0] shift_plane,
    input  logic                 shift_done,
    output logic [ROWBITS-1:0]   led_addr,
    output logic                 led_blank,
    output logic                 led_latch,
    output logic                 frame_start,
    output logic                 busy
);

    localparam int TW = timer_width(BASE_CYCLES, PLANES);
    localparam logic [ROWBITS-1:0]   LAST_ROW   = ROWBITS'(ROWS - 1);
    localparam logic [PLANEBITS-1:0] LAST_PLANE = PLANEBITS'(PLANES - 1);

    if (COLS < 1 || ROWS > (1 << ROWBITS) || PLANES > (1 << PLANEBITS)) begin : g_param_check
        $error("hub75_scan_sched: inconsistent parameters");
    end

    state_t                state, state_next;
    logic                  inflight, staged, stopped;
    logic [ROWBITS-1:0]    held_row;
    logic [PLANEBITS-1:0]  held_plane;
    logic                  accept, done_ok, done_now, want_issue, at_origin;
    logic                  timer_zero;
    logic [TW-1:0]         timer_value;

    // valid/ready: the command (shift_row, shift_plane) is held stable while
    // shift_valid is high and is consumed on the cycle both are high.
    assign accept     = shift_valid && shift_ready;
    assign done_ok    = shift_done && inflight;
    assign done_now   = staged || done_ok;
    assign at_origin  = (shift_row == '0) && (shift_plane == '0);
    // LATCH frees the staging slot, so the next command can go out right after.
    assign want_issue = busy && !stopped && !inflight && !shift_valid
                        && !(staged && state != S_LATCH);

    assign busy        = (state != S_IDLE);
    assign led_blank   = (state != S_DISPLAY);
    assign led_latch   = (state == S_LATCH);
    assign frame_start = accept && at_origin;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_valid <= 1'b0;
            shift_row   <= '0;
            shift_plane <= '0;
            inflight    <= 1'b0;
            staged      <= 1'b0;
            stopped     <= 1'b0;
            held_row    <= '0;
            held_plane  <= '0;
        end else begin
            if (want_issue) begin
                if (at_origin && !enable) stopped <= 1'b1;
                else                      shift_valid <= 1'b1;
            end
            if (accept) begin
                shift_valid <= 1'b0;
                inflight    <= 1'b1;
                held_row    <= shift_row;
                held_plane  <= shift_plane;
                if (shift_plane == LAST_PLANE) begin
                    shift_plane <= '0;
                    shift_row   <= (shift_row == LAST_ROW) ? '0 : shift_row + ROWBITS'(1);
                end else begin
                    shift_plane <= shift_plane + PLANEBITS'(1);
                end
            end
            if (done_ok) begin
                inflight <= 1'b0;
                staged   <= 1'b1;
            end
            if (state == S_LATCH) staged  <= 1'b0;
            if (state == S_IDLE)  stopped <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            led_addr <= '0;
        end else begin
            state <= state_next;
            if (state == S_LATCH) led_addr <= held_row;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (enable) state_next = S_WAIT;
            S_WAIT: begin
                if (done_now) state_next = S_BLANK;
                else if (stopped && !inflight && !shift_valid) state_next = S_IDLE;
            end
            S_BLANK:   state_next = S_LATCH;
            S_LATCH:   state_next = S_UNBLANK;
            S_UNBLANK: state_next = S_DISPLAY;
            S_DISPLAY: begin
                if (timer_zero) begin
                    if (done_now) state_next = S_BLANK;
                    else if (!inflight && !shift_valid) state_next = S_IDLE;
                end
            end
            default:   state_next = S_IDLE;
        endcase
    end

    // The timer holds cycles remaining after the current one, so loading
    // weight-1 gives exactly 'weight' unblanked cycles.
    assign timer_value = (TW'(BASE_CYCLES) << held_plane) - TW'(1);

    hub75_plane_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (state == S_UNBLANK),
        .value (timer_value),
        .dec   (state == S_DISPLAY),
        .zero  (timer_zero)
    );

endmodule
